// File: rtl/decode_control.sv
// Decode stage: instruction field extraction, control decode, stall/bubble
// generation and a 32-entry register file with combinational reads.
module decode_control #(
    parameter int INST_WIDTH     = 32,
    parameter int REG_FILE_WIDTH = 32,
    parameter int ADDR_WIDTH     = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [INST_WIDTH-1:0]     instruction,
    input  logic                      block_pipe_data_cache,
    input  logic                      block_pipe_instr_cache,
    input  logic                      wrt_en,
    input  logic [ADDR_WIDTH-1:0]     addrD,
    input  logic [REG_FILE_WIDTH-1:0] data_d,
    output logic [REG_FILE_WIDTH-1:0] data_a,
    output logic [REG_FILE_WIDTH-1:0] data_b,
    output logic [REG_FILE_WIDTH-1:0] imm_ext,
    output logic [ADDR_WIDTH-1:0]     regA,
    output logic [ADDR_WIDTH-1:0]     regB,
    output logic [ADDR_WIDTH-1:0]     regD,
    output logic [1:0]                ALU_OP,
    output logic                      ALU_REG_DEST,
    output logic                      is_immediate,
    output logic                      is_branch,
    output logic                      MEM_R_EN,
    output logic                      MEM_W_EN,
    output logic                      MEM_TO_REG,
    output logic                      WB_EN,
    output logic                      EN_REG_FETCH,
    output logic                      EN_REG_DECODE,
    output logic                      EN_REG_ALU,
    output logic                      EN_REG_MEM,
    output logic                      injecting_nop
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_MUL  = 6'h03;
    localparam logic [5:0] OP_ADDI = 6'h04;
    localparam logic [5:0] OP_LDW  = 6'h10;
    localparam logic [5:0] OP_STW  = 6'h11;
    localparam logic [5:0] OP_BEQ  = 6'h30;

    logic [INST_WIDTH-1:0]     sel_instr;
    logic [5:0]                opcode;
    logic [REG_FILE_WIDTH-1:0] regs [NUM_REGS];

    // A data-cache stall freezes everything; an instruction-cache stall
    // holds fetch only and lets a bubble flow down the rest of the pipe.
    always_comb begin
        EN_REG_FETCH  = 1'b1;
        EN_REG_DECODE = 1'b1;
        EN_REG_ALU    = 1'b1;
        EN_REG_MEM    = 1'b1;
        injecting_nop = 1'b0;
        if (block_pipe_data_cache) begin
            EN_REG_FETCH  = 1'b0;
            EN_REG_DECODE = 1'b0;
            EN_REG_ALU    = 1'b0;
            EN_REG_MEM    = 1'b0;
        end else if (block_pipe_instr_cache) begin
            EN_REG_FETCH  = 1'b0;
            injecting_nop = 1'b1;
        end
    end

    assign sel_instr = injecting_nop ? '0 : instruction;
    assign opcode    = sel_instr[31:26];
    assign regA      = sel_instr[25:21];
    assign regB      = sel_instr[20:16];
    assign imm_ext   = {{(REG_FILE_WIDTH-16){1'b0}}, sel_instr[15:0]};

    always_comb begin
        ALU_OP       = 2'b00;
        ALU_REG_DEST = 1'b0;
        is_immediate = 1'b0;
        is_branch    = 1'b0;
        MEM_R_EN     = 1'b0;
        MEM_W_EN     = 1'b0;
        MEM_TO_REG   = 1'b0;
        WB_EN        = 1'b0;
        regD         = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL: begin
                ALU_OP       = (opcode == OP_SUB) ? 2'b01 :
                               (opcode == OP_MUL) ? 2'b10 : 2'b00;
                ALU_REG_DEST = 1'b1;
                WB_EN        = 1'b1;
                regD         = sel_instr[15:11];
            end
            OP_ADDI: begin
                is_immediate = 1'b1;
                WB_EN        = 1'b1;
                regD         = sel_instr[20:16];
            end
            OP_LDW: begin
                is_immediate = 1'b1;
                MEM_R_EN     = 1'b1;
                MEM_TO_REG   = 1'b1;
                WB_EN        = 1'b1;
                regD         = sel_instr[20:16];
            end
            OP_STW: begin
                is_immediate = 1'b1;
                MEM_W_EN     = 1'b1;
            end
            OP_BEQ: begin
                ALU_OP    = 2'b01;
                is_branch = 1'b1;
            end
            OP_NOP:  ;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wrt_en && (addrD != '0)) begin
            regs[addrD] <= data_d;
        end
    end

    // No bypass: reads see the array contents from before the current edge.
    assign data_a = (regA == '0) ? '0 : regs[regA];
    assign data_b = (regB == '0) ? '0 : regs[regB];

endmodule

// File: tb/tb_decode_control.sv
// Bench for decode_control: directed literal checks, then randomized traffic
// compared every cycle against a behavioural model of decode and register file.
module tb_decode_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        block_pipe_data_cache;
    logic        block_pipe_instr_cache;
    logic        wrt_en;
    logic [4:0]  addrD;
    logic [31:0] data_d;
    logic [31:0] data_a, data_b, imm_ext;
    logic [4:0]  regA, regB, regD;
    logic [1:0]  ALU_OP;
    logic        ALU_REG_DEST, is_immediate, is_branch;
    logic        MEM_R_EN, MEM_W_EN, MEM_TO_REG, WB_EN;
    logic        EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM;
    logic        injecting_nop;

    int errors = 0;
    int checks = 0;
    bit model_on = 1'b0;
    logic [31:0] model_regs [32];

    decode_control dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .block_pipe_data_cache(block_pipe_data_cache),
        .block_pipe_instr_cache(block_pipe_instr_cache),
        .wrt_en(wrt_en), .addrD(addrD), .data_d(data_d),
        .data_a(data_a), .data_b(data_b), .imm_ext(imm_ext),
        .regA(regA), .regB(regB), .regD(regD), .ALU_OP(ALU_OP),
        .ALU_REG_DEST(ALU_REG_DEST), .is_immediate(is_immediate),
        .is_branch(is_branch), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .MEM_TO_REG(MEM_TO_REG), .WB_EN(WB_EN),
        .EN_REG_FETCH(EN_REG_FETCH), .EN_REG_DECODE(EN_REG_DECODE),
        .EN_REG_ALU(EN_REG_ALU), .EN_REG_MEM(EN_REG_MEM),
        .injecting_nop(injecting_nop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Controls packed as {ALU_OP, ALU_REG_DEST, is_immediate, is_branch,
    // MEM_R_EN, MEM_W_EN, MEM_TO_REG, WB_EN}.
    function automatic logic [8:0] dut_ctrl();
        return {ALU_OP, ALU_REG_DEST, is_immediate, is_branch,
                MEM_R_EN, MEM_W_EN, MEM_TO_REG, WB_EN};
    endfunction

    function automatic logic [8:0] exp_ctrl(input logic [31:0] ins);
        logic [5:0] op = ins[31:26];
        case (op)
            6'h01:   return 9'b00_1_0_0_0_0_0_1;
            6'h02:   return 9'b01_1_0_0_0_0_0_1;
            6'h03:   return 9'b10_1_0_0_0_0_0_1;
            6'h04:   return 9'b00_0_1_0_0_0_0_1;
            6'h10:   return 9'b00_0_1_0_1_0_1_1;
            6'h11:   return 9'b00_0_1_0_0_1_0_0;
            6'h30:   return 9'b01_0_0_1_0_0_0_0;
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic [4:0] exp_regd(input logic [31:0] ins);
        logic [5:0] op = ins[31:26];
        if (op >= 6'h01 && op <= 6'h03) return ins[15:11];
        if (op == 6'h04 || op == 6'h10) return ins[20:16];
        return 5'd0;
    endfunction

    // Model register file: same edge semantics as a real array, r0 hardwired.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) model_regs[i] <= 32'd0;
        end else if (wrt_en && addrD != 5'd0) begin
            model_regs[addrD] <= data_d;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            logic        dc, ic, inj;
            logic [31:0] sel;
            logic [4:0]  ra, rb;
            dc  = block_pipe_data_cache;
            ic  = block_pipe_instr_cache;
            inj = ic && !dc;
            sel = inj ? 32'd0 : instruction;
            ra  = sel[25:21];
            rb  = sel[20:16];
            check("m_stall", {EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM, injecting_nop},
                  dc ? 5'b0000_0 : (ic ? 5'b0111_1 : 5'b1111_0));
            check("m_ctrl", dut_ctrl(), exp_ctrl(sel));
            check("m_fields", {regA, regB, regD}, {ra, rb, exp_regd(sel)});
            check("m_imm", imm_ext, {16'd0, sel[15:0]});
            check("m_data_a", data_a, (ra == 0) ? 32'd0 : model_regs[ra]);
            check("m_data_b", data_b, (rb == 0) ? 32'd0 : model_regs[rb]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] ops [8];
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h10, 6'h11, 6'h30};

        reset = 1'b1; instruction = 32'd0; block_pipe_data_cache = 1'b0;
        block_pipe_instr_cache = 1'b0; wrt_en = 1'b0; addrD = 5'd0; data_d = 32'd0;
        step();
        step();
        reset = 1'b0;
        model_on = 1'b1;
        #1;

        // All registers read zero after reset.
        for (int r = 1; r < 32; r++) begin
            instruction = {6'h01, r[4:0], r[4:0], 16'd0};
            #1;
            check("rst_data_a", data_a, 32'd0);
            check("rst_data_b", data_b, 32'd0);
        end

        // Write r3; before the edge the old value is still visible.
        instruction = {6'h01, 5'd3, 5'd0, 16'd0};
        wrt_en = 1'b1; addrD = 5'd3; data_d = 32'hDEAD_BEEF;
        #1;
        check("pre_edge_read", data_a, 32'd0);
        step();
        wrt_en = 1'b0;
        #1;
        check("post_edge_read", data_a, 32'hDEAD_BEEF);

        // r0 ignores writes.
        wrt_en = 1'b1; addrD = 5'd0; data_d = 32'h1234_5678;
        step();
        wrt_en = 1'b0;
        instruction = {6'h01, 5'd0, 5'd3, 16'd0};
        #1;
        check("r0_read", data_a, 32'd0);
        check("r3_on_b", data_b, 32'hDEAD_BEEF);

        instruction = {6'h01, 5'd1, 5'd2, 5'd5, 11'd0};
        #1;
        check("add_ctrl", dut_ctrl(), 9'b00_1_0_0_0_0_0_1);
        check("add_regd", regD, 5'd5);

        instruction = {6'h10, 5'd0, 5'd7, 16'h8001};
        #1;
        check("ldw_ctrl", dut_ctrl(), 9'b00_0_1_0_1_0_1_1);
        check("ldw_regd", regD, 5'd7);
        check("ldw_imm", imm_ext, 32'h0000_8001);

        instruction = {6'h01, 5'd3, 5'd3, 5'd5, 11'd0};
        block_pipe_instr_cache = 1'b1;
        #1;
        check("ic_stall_en", {EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM}, 4'b0111);
        check("ic_stall_inj", injecting_nop, 1'b1);
        check("ic_stall_wb", WB_EN, 1'b0);
        check("ic_stall_data", data_a, 32'd0);
        block_pipe_data_cache = 1'b1;
        #1;
        check("dc_stall_en", {EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM}, 4'b0000);
        check("dc_stall_inj", injecting_nop, 1'b0);
        check("dc_stall_wb", WB_EN, 1'b1);
        block_pipe_data_cache = 1'b0; block_pipe_instr_cache = 1'b0;

        instruction = {6'h3F, 26'h3FF_FFFF};
        #1;
        check("unk_ctrl", dut_ctrl(), 9'd0);
        check("unk_regd", regD, 5'd0);

        // Reset wins over a simultaneous write.
        instruction = {6'h01, 5'd3, 5'd0, 16'd0};
        reset = 1'b1; wrt_en = 1'b1; addrD = 5'd3; data_d = 32'h5555_5555;
        step();
        reset = 1'b0; wrt_en = 1'b0;
        #1;
        check("rst_prio", data_a, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            step();
            instruction = $urandom;
            if ($urandom_range(0, 3) != 0)
                instruction[31:26] = ops[$urandom_range(0, 7)];
            block_pipe_data_cache  = ($urandom_range(0, 7) == 0);
            block_pipe_instr_cache = ($urandom_range(0, 5) == 0);
            wrt_en = ($urandom_range(0, 1) == 1);
            addrD  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) addrD = instruction[25:21];
            data_d = $urandom;
            reset  = ($urandom_range(0, 199) == 0);
        end
        step();
        reset = 1'b0; wrt_en = 1'b0;
        @(negedge clk);
        #1;
        model_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_control.md
DECODE_CONTROL -- requirements
Module: decode_control

Interface
REQ-001 SHALL have parameter INST_WIDTH, default 32, instruction width.
REQ-002 SHALL have parameter REG_FILE_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 5, register address width (32 registers).
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-005 SHALL have ports:
- clk  in  1  clock, all state changes on rising edge.
- reset  in  1  synchronous active-high reset.
- instruction  in  32  instruction from fetch.
- block_pipe_data_cache  in  1  data cache busy.
- block_pipe_instr_cache  in  1  instruction cache busy.
- wrt_en  in  1  register-file write enable.
- addrD  in  5  register-file write address.
- data_d  in  32  register-file write data.
- data_a, data_b  out  32  read data for regA/regB.
- imm_ext  out  32  zero-extended instr[15:0].
- regA, regB, regD  out  5  source/destination register addresses.
- ALU_OP  out  2  ALU operation.
- ALU_REG_DEST, is_immediate, is_branch, MEM_R_EN, MEM_W_EN, MEM_TO_REG, WB_EN  out  1 each  decoded controls.
- EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM  out  1 each  pipeline-register enables.
- injecting_nop  out  1  high when the instruction is replaced by NOP.

Function
REQ-006 Fields: opcode=instr[31:26], regA=instr[25:21], regB=instr[20:16], imm=instr[15:0].
REQ-007 Bubble mux: selected instruction = 32'h0000_0000 when injecting_nop=1, else instruction; all decoded outputs, regA/regB/regD and imm_ext SHALL derive from the selected instruction.
REQ-008 Decode (unlisted outputs 0):
- 0x00 NOP: all controls 0, regD=0.
- 0x01 ADD: ALU_OP=00, ALU_REG_DEST=1, WB_EN=1, regD=instr[15:11].
- 0x02 SUB: as ADD, ALU_OP=01.
- 0x03 MUL: as ADD, ALU_OP=10.
- 0x04 ADDI: ALU_OP=00, is_immediate=1, WB_EN=1, regD=instr[20:16].
- 0x10 LDW: ALU_OP=00, is_immediate=1, MEM_R_EN=1, MEM_TO_REG=1, WB_EN=1, regD=instr[20:16].
- 0x11 STW: ALU_OP=00, is_immediate=1, MEM_W_EN=1, regD=0.
- 0x30 BEQ: ALU_OP=01, is_branch=1, regD=0.
- any other opcode: decoded as NOP.
REQ-009 Stall: block_pipe_data_cache=1 -> all four EN_REG_*=0, injecting_nop=0 (priority over instr cache).
REQ-010 block_pipe_instr_cache=1 only -> EN_REG_FETCH=0, others 1, injecting_nop=1.
REQ-011 No block -> all EN_REG_*=1, injecting_nop=0.
REQ-012 All control/decode outputs combinational (zero latency).
REQ-013 Register file: 32x32; reads combinational on regA/regB; write of data_d to addrD on rising clk when wrt_en=1.
REQ-014 Register 0 SHALL read 0 always; writes to it ignored.
REQ-015 No write-to-read bypass: a same-cycle read of addrD returns the old value until after the edge.
REQ-016 imm_ext = {16'b0, imm}.

Reset
REQ-017 reset=1 at a rising edge SHALL clear all 32 registers to 0; reset takes priority over wrt_en in the same cycle.
REQ-018 Decode/stall outputs are combinational and not affected by reset.

Verification
REQ-019 reset, then read r1..r31 -> data_a=data_b=0.
REQ-020 wrt_en=1, addrD=3, data_d=0xDEADBEEF, edge; regA=3 -> data_a=0xDEADBEEF; same cycle pre-edge read -> 0; write to r0 -> reads 0.
REQ-021 instruction opcode 0x01, rA=1, rB=2, rD=5 -> ALU_OP=00, WB_EN=1, ALU_REG_DEST=1, regD=5.
REQ-022 opcode 0x10, [20:16]=7, imm=0x8001 -> MEM_R_EN=MEM_TO_REG=WB_EN=is_immediate=1, regD=7, imm_ext=0x00008001.
REQ-023 ADD with block_pipe_instr_cache=1 -> injecting_nop=1, WB_EN=0, EN_REG_FETCH=0, others 1; add block_pipe_data_cache=1 -> all EN_REG_*=0, injecting_nop=0.
REQ-024 unknown opcode 0x3F -> all controls 0, regD=0.
